comparator_arbiter: RTL
=======================

# comparator_arbiter

Shares one 8-bit dual-mode (signed/unsigned) comparator datapath between `N_REQ` requesters. Each requester submits an operand pair and a mode bit over a valid/ready handshake. A round-robin arbiter grants one request at a time and sequences it through a registered compare stage. The result returns on a single tagged response channel. It sits between the switch/button front-ends and the LED/display logic in the comparator test designs, replacing per-client comparator instances.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 8: operand width.
- `ID_W`, `$clog2(N_REQ)`: width of the requester tag.

- `clk`: input, 1, system clock; all logic on the rising edge.
- `reset_n`: input, 1, synchronous, active-low reset.
- `req_valid`: input, N_REQ, per-requester request valid.
- `req_ready`: output, N_REQ, per-requester accept; one-hot or zero.
- `req_a`: input, N_REQ*W, operand A; requester i occupies bits `[i*W +: W]`.
- `req_b`: input, N_REQ*W, operand B; same packing as `req_a`.
- `req_signed`: input, N_REQ, 1 = two's-complement compare, 0 = unsigned.
- `resp_valid`: output, 1, response valid.
- `resp_ready`: input, 1, response consumer accept.
- `resp_id`: output, ID_W, index of the requester this response belongs to.
- `resp_gt`: output, 1, 1 when A > B under the selected mode.

## Operation
- FSM states: IDLE, CMP, RESP. Reset state is IDLE.
- IDLE:
  - Grant the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap from N_REQ-1 to 0.
  - `req_ready` is high only for the granted index and is combinational from `req_valid` and `rr_ptr`.
  - On handshake: latch A, B, mode and id; set `rr_ptr` = granted index + 1 mod N_REQ; go to CMP.
  - If no request is valid, stay in IDLE with `rr_ptr` unchanged.
- CMP:
  - Evaluate the comparator on the latched operands.
  - Register `resp_gt` (and `resp_eq` when configured).
  - Set `resp_valid`; go to RESP.
- RESP:
  - Hold `resp_valid`, `resp_id` and the result stable until `resp_ready` is high.
  - On that cycle, go to IDLE.
- `req_ready` is all-zero in CMP and RESP. One transaction is in flight at most.
- Signed compare: MSB is the sign bit. Unsigned compare: plain magnitude. No width extension is visible at ports.
- A requester that drops `req_valid` before being granted loses nothing. No partial state is kept.
- Reset asserted in any state:
  - Return to IDLE; clear `rr_ptr` to 0.
  - Drop any in-flight transaction. No response is emitted for it.

## Timing
- Reset values: `req_ready` = 0 while `reset_n` is low, `resp_valid` = 0, `resp_id` = 0, `resp_gt` = 0, `resp_eq` = 0.
- Request handshake in cycle T leads to `resp_valid` high in cycle T+2.
- With `resp_ready` held high, the response completes in T+2 and the next grant can occur in T+3. Peak throughput is one compare per 3 cycles.
- Backpressure: `resp_ready` low stalls in RESP indefinitely. Outputs must not change while stalled.
- Fairness with all requesters continuously valid and `resp_ready` = 1:
  - Grant order is 0, 1, …, N_REQ-1, 0, …
  - No requester waits more than N_REQ-1 other transactions.

## Configuration
- `CMP_ARB_EQ_EN` defined:
  - Adds output port `resp_eq` (1 bit).
  - `resp_eq` = 1 when A == B; the result is mode-independent.
  - Registered and held with the same timing as `resp_gt`.
- `CMP_ARB_EQ_EN` undefined:
  - `resp_eq` is absent along with its register.
  - All other behaviour is identical.

## Structure
- Package `cmp_arb_pkg` holds:
  - FSM state encoding constants (IDLE, CMP, RESP).
  - Default `W` and `N_REQ`.
- Sub-module `dual_mode_compare`: purely combinational; inputs `a`, `b`, `is_signed`; outputs `gt` and `eq`. It is instantiated once.
- The arbiter contains the round-robin grant logic, the FSM and the operand/result registers.

## Test plan
- Reset mid-RESP: assert `reset_n` = 0 for one cycle while `resp_valid` = 1 → next cycle `resp_valid` = 0, state IDLE, `rr_ptr` = 0.
- Single unsigned request: requester 2, A = 8'h80, B = 8'h7F, `req_signed` = 0 → `resp_valid` at T+2, `resp_id` = 2, `resp_gt` = 1.
- Same operands with `req_signed` = 1 → `resp_gt` = 0. Also A = B = 8'h55 → `resp_gt` = 0, and `resp_eq` = 1 when `CMP_ARB_EQ_EN` is defined.
- All four requesters valid continuously, `resp_ready` = 1 → `resp_id` sequence 0, 1, 2, 3, 0, with successive `resp_valid` pulses 3 cycles apart.
- Backpressure: hold `resp_ready` = 0 for 5 cycles → `resp_valid`, `resp_id` and `resp_gt` stay stable, all `req_ready` bits stay 0, and exactly one response is consumed when `resp_ready` rises.

Source files
------------

// File: rtl/cmp_arb_pkg.sv
// Shared definitions for the comparator arbiter: FSM encoding and default sizes.
package cmp_arb_pkg;

    localparam int unsigned CMP_ARB_W_DEFAULT     = 8;
    localparam int unsigned CMP_ARB_N_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } cmp_arb_state_e;

endpackage

// File: rtl/dual_mode_compare.sv
// Combinational W-bit comparator, two's-complement or unsigned per is_signed.
module dual_mode_compare
    import cmp_arb_pkg::*;
#(
    parameter int unsigned W = CMP_ARB_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic         gt,
    output logic         eq
);

    assign gt = is_signed ? ($signed(a) > $signed(b)) : (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/comparator_arbiter.sv
// Round-robin shared comparator: N_REQ requesters, one registered compare, tagged response.
// Optional resp_eq output is enabled by defining CMP_ARB_EQ_EN.
module comparator_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int unsigned N_REQ = CMP_ARB_N_REQ_DEFAULT,
    parameter int unsigned W     = CMP_ARB_W_DEFAULT,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_signed,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic               resp_gt
`ifdef CMP_ARB_EQ_EN
    ,
    output logic               resp_eq
`endif
);

    cmp_arb_state_e  r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_signed;
    logic [ID_W-1:0] r_id;
    logic            r_resp_valid;
    logic [ID_W-1:0] r_resp_id;
    logic            r_resp_gt;

    logic            w_found;
    logic [ID_W-1:0] w_grant_idx;
    logic [ID_W-1:0] w_next_ptr;
    logic [N_REQ-1:0] w_ready;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_sel_s;
    logic            w_gt;
    logic            w_eq;

    // First valid requester at or after r_rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int unsigned v_sum;
        logic [ID_W-1:0] v_cand;
        w_found     = 1'b0;
        w_grant_idx = '0;
        v_sum       = 0;
        v_cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            v_sum = 32'(r_rr_ptr) + k;
            if (v_sum >= N_REQ) begin
                v_sum = v_sum - N_REQ;
            end
            v_cand = ID_W'(v_sum);
            if (!w_found && req_valid[v_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = v_cand;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_s = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == w_grant_idx) begin
                w_sel_a = req_a[k*W +: W];
                w_sel_b = req_b[k*W +: W];
                w_sel_s = req_signed[k];
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
    assign w_ready    = (reset_n && (r_state == IDLE) && w_found)
                        ? (N_REQ'(1) << w_grant_idx) : '0;

    dual_mode_compare #(.W(W)) u_cmp (
        .a         (r_a),
        .b         (r_b),
        .is_signed (r_signed),
        .gt        (w_gt),
        .eq        (w_eq)
    );

`ifdef CMP_ARB_EQ_EN
    logic r_resp_eq;
    assign resp_eq = r_resp_eq;
`else
    logic w_eq_unused;
    assign w_eq_unused = w_eq;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_signed     <= 1'b0;
            r_id         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_gt    <= 1'b0;
`ifdef CMP_ARB_EQ_EN
            r_resp_eq    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_signed <= w_sel_s;
                        r_id     <= w_grant_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= CMP;
                    end
                end
                CMP: begin
                    r_resp_gt    <= w_gt;
`ifdef CMP_ARB_EQ_EN
                    r_resp_eq    <= w_eq;
`endif
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    // Result registers hold until the consumer accepts.
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_gt    = r_resp_gt;

endmodule
